// File: rtl/dq02abc_scheduler.sv
// Shares one pipelined dq0-to-abc transform unit across N_CH channels per time step.
// Enabled channels issue in ascending order; a tag pipe routes each result back to its channel.
module dq02abc_scheduler #(
  parameter int N_CH    = 4,
  parameter int LATENCY = 24,
  parameter int W       = 64,
  parameter int CW      = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step_sta,
  input  logic [N_CH-1:0]   ch_en,
  input  logic [N_CH*W-1:0] vd_bus,
  input  logic [N_CH*W-1:0] vq_bus,
  input  logic [N_CH*W-1:0] sin_bus,
  input  logic [N_CH*W-1:0] cos_bus,
  output logic              dq_sta,
  output logic [W-1:0]      dq_Vd,
  output logic [W-1:0]      dq_Vq,
  output logic [W-1:0]      dq_sin,
  output logic [W-1:0]      dq_cos,
  input  logic [W-1:0]      dq_Va,
  input  logic [W-1:0]      dq_Vb,
  input  logic [W-1:0]      dq_Vc,
  input  logic              dq_done,
  output logic [W-1:0]      res_Va,
  output logic [W-1:0]      res_Vb,
  output logic [W-1:0]      res_Vc,
  output logic [CW-1:0]     res_ch,
  output logic              res_valid,
  output logic              step_done,
  output logic              busy,
  output logic              overrun,
  output logic              tag_err,
  output logic [1:0]        fsm_state
);

  localparam int CNTW = $clog2(N_CH + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2, FIN = 2'd3} state_t;

  state_t             state, state_nxt;
  logic [N_CH-1:0]    pending, src_mask, rem_mask;
  logic [CW-1:0]      sel, dq_ix;
  logic               accept, issue, fin;
  logic [LATENCY-1:0] tv_pipe;
  logic [CW-1:0]      ti_pipe [LATENCY];
  logic               tag_v;
  logic [CW-1:0]      tag_ix;
  logic [CNTW-1:0]    cnt, cnt_nxt;

  // Strobe semantics: dq_sta and dq_done are single-cycle, fire-and-forget strobes with no
  // backpressure; the transform unit accepts one start per cycle and returns exactly LATENCY later.
  assign accept   = step_sta & ~busy;
  assign src_mask = (state == IDLE) ? ch_en : pending;
  assign tag_v    = tv_pipe[LATENCY-1];
  assign tag_ix   = ti_pipe[LATENCY-1];
  assign cnt_nxt  = cnt + CNTW'(issue) - CNTW'(tag_v);

  always_comb begin
    sel = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (src_mask[i]) sel = CW'(i);
    end
  end

  assign rem_mask = src_mask & ~(N_CH'(1) << sel);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // The first channel issues on the accepting edge so dq_sta follows step_sta by one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (ch_en == '0)         state_nxt = FIN;
          else if (rem_mask != '0) state_nxt = ISSUE;
          else                     state_nxt = DRAIN;
        end
      end
      ISSUE:   if (rem_mask == '0) state_nxt = DRAIN;
      DRAIN:   if (cnt_nxt == '0)  state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    issue     = 1'b0;
    fin       = 1'b0;
    fsm_state = state;
    case (state)
      IDLE:    issue = accept & (|ch_en);
      ISSUE:   issue = |pending;
      FIN:     fin   = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dq_sta    <= 1'b0;
      dq_Vd     <= '0;
      dq_Vq     <= '0;
      dq_sin    <= '0;
      dq_cos    <= '0;
      dq_ix     <= '0;
      pending   <= '0;
      tv_pipe   <= '0;
      for (int k = 0; k < LATENCY; k++) ti_pipe[k] <= '0;
      cnt       <= '0;
      res_Va    <= '0;
      res_Vb    <= '0;
      res_Vc    <= '0;
      res_ch    <= '0;
      res_valid <= 1'b0;
      step_done <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      tag_err   <= 1'b0;
    end else begin
      dq_sta <= issue;
      if (issue) begin
        dq_Vd   <= vd_bus[int'(sel)*W +: W];
        dq_Vq   <= vq_bus[int'(sel)*W +: W];
        dq_sin  <= sin_bus[int'(sel)*W +: W];
        dq_cos  <= cos_bus[int'(sel)*W +: W];
        dq_ix   <= sel;
        pending <= rem_mask;
      end
      // Tag pipe is fed from the registered start so its tail lines up with dq_done.
      tv_pipe    <= {tv_pipe[LATENCY-2:0], dq_sta};
      ti_pipe[0] <= dq_ix;
      for (int k = 1; k < LATENCY; k++) ti_pipe[k] <= ti_pipe[k-1];
      cnt <= cnt_nxt;

      res_valid <= dq_done & tag_v;
      if (dq_done & tag_v) begin
        res_Va <= dq_Va;
        res_Vb <= dq_Vb;
        res_Vc <= dq_Vc;
        res_ch <= tag_ix;
      end
      if (dq_done != tag_v) tag_err <= 1'b1;
      if (step_sta & busy)  overrun <= 1'b1;

      step_done <= fin;
      if (accept)         busy <= 1'b1;
      else if (step_done) busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dq02abc_scheduler.sv
// Directed bench for dq02abc_scheduler: a behavioural transform unit plus queued expectations
// for issues, results and step completion, checked at the falling edge.
module tb_dq02abc_scheduler;

  localparam int N  = 4;
  localparam int L  = 24;
  localparam int W  = 64;
  localparam int CW = 2;

  typedef struct packed {
    int            cyc;
    logic [CW-1:0] ch;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [W-1:0]  c;
    logic [W-1:0]  d;
  } ent_t;

  logic           clk, rst, step_sta;
  logic [N-1:0]   ch_en;
  logic [N*W-1:0] vd_bus, vq_bus, sin_bus, cos_bus;
  logic           dq_sta;
  logic [W-1:0]   dq_Vd, dq_Vq, dq_sin, dq_cos;
  logic [W-1:0]   dq_Va, dq_Vb, dq_Vc;
  logic           dq_done;
  logic [W-1:0]   res_Va, res_Vb, res_Vc;
  logic [CW-1:0]  res_ch;
  logic           res_valid, step_done, busy, overrun, tag_err;
  logic [1:0]     fsm_state;

  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   force_cyc = -1;
  int   kill_cyc = -1;
  bit   exp_overrun = 0;
  bit   exp_tag_err = 0;
  ent_t iss_q[$];
  ent_t res_q[$];
  int   done_q[$];
  logic [W-1:0] op_vd[N], op_vq[N], op_sin[N], op_cos[N];

  dq02abc_scheduler #(.N_CH(N), .LATENCY(L), .W(W), .CW(CW)) dut (
    .clk(clk), .rst(rst), .step_sta(step_sta), .ch_en(ch_en),
    .vd_bus(vd_bus), .vq_bus(vq_bus), .sin_bus(sin_bus), .cos_bus(cos_bus),
    .dq_sta(dq_sta), .dq_Vd(dq_Vd), .dq_Vq(dq_Vq), .dq_sin(dq_sin), .dq_cos(dq_cos),
    .dq_Va(dq_Va), .dq_Vb(dq_Vb), .dq_Vc(dq_Vc), .dq_done(dq_done),
    .res_Va(res_Va), .res_Vb(res_Vb), .res_Vc(res_Vc), .res_ch(res_ch),
    .res_valid(res_valid), .step_done(step_done), .busy(busy),
    .overrun(overrun), .tag_err(tag_err), .fsm_state(fsm_state)
  );

  // Clock and cycle counter: cycle c is the interval after the c-th rising edge.
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic logic [W-1:0] f_a(input logic [W-1:0] vd, input logic [W-1:0] vq);
    return vd ^ vq;
  endfunction
  function automatic logic [W-1:0] f_b(input logic [W-1:0] vd, input logic [W-1:0] s);
    return vd + s;
  endfunction
  function automatic logic [W-1:0] f_c(input logic [W-1:0] c, input logic [W-1:0] vq);
    return c - vq;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Transform unit model: fixed latency L, driven at the falling edge, cleared by rst.
  logic         mv[L];
  logic [W-1:0] ma[L], mb[L], mc[L];
  initial begin
    for (int k = 0; k < L; k++) begin
      mv[k] = 0; ma[k] = '0; mb[k] = '0; mc[k] = '0;
    end
    dq_done = 0; dq_Va = '0; dq_Vb = '0; dq_Vc = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int k = 0; k < L; k++) mv[k] = 0;
        dq_done = 0;
      end else begin
        dq_done = mv[L-1];
        dq_Va   = ma[L-1];
        dq_Vb   = mb[L-1];
        dq_Vc   = mc[L-1];
        if (cyc == kill_cyc)  dq_done = 0;
        if (cyc == force_cyc) dq_done = 1;
        for (int k = L - 1; k > 0; k--) begin
          mv[k] = mv[k-1]; ma[k] = ma[k-1]; mb[k] = mb[k-1]; mc[k] = mc[k-1];
        end
        mv[0] = dq_sta;
        ma[0] = f_a(dq_Vd, dq_Vq);
        mb[0] = f_b(dq_Vd, dq_sin);
        mc[0] = f_c(dq_cos, dq_Vq);
      end
    end
  end

  // Scoreboard monitor: every strobe must match the head of its expected queue.
  initial forever begin
    ent_t e;
    int   d;
    @(negedge clk);
    if (dq_sta) begin
      if (iss_q.size() == 0) chk("dq_sta_unexpected", dq_sta, 0);
      else begin
        e = iss_q.pop_front();
        chk("iss_cyc", cyc, e.cyc);
        chk("iss_vd", dq_Vd, e.a);
        chk("iss_vq", dq_Vq, e.b);
        chk("iss_sin", dq_sin, e.c);
        chk("iss_cos", dq_cos, e.d);
      end
    end
    if (res_valid) begin
      if (res_q.size() == 0) chk("res_valid_unexpected", res_valid, 0);
      else begin
        e = res_q.pop_front();
        chk("res_cyc", cyc, e.cyc);
        chk("res_ch", res_ch, e.ch);
        chk("res_va", res_Va, e.a);
        chk("res_vb", res_Vb, e.b);
        chk("res_vc", res_Vc, e.c);
      end
    end
    if (step_done) begin
      if (done_q.size() == 0) chk("step_done_unexpected", step_done, 0);
      else begin
        d = done_q.pop_front();
        chk("done_cyc", cyc, d);
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_dq_sta"}, dq_sta, 0);
    chk({tag, "_dq_vd"}, dq_Vd, 0);
    chk({tag, "_dq_cos"}, dq_cos, 0);
    chk({tag, "_res_va"}, res_Va, 0);
    chk({tag, "_res_vc"}, res_Vc, 0);
    chk({tag, "_res_ch"}, res_ch, 0);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_step_done"}, step_done, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_overrun"}, overrun, 0);
    chk({tag, "_tag_err"}, tag_err, 0);
    chk({tag, "_fsm_state"}, fsm_state, 0);
  endtask

  // One time step. Offsets are relative to the step_sta cycle; -1 disables the option.
  task automatic run_step(input logic [N-1:0] mask, input int sta2_off, input int force_off,
                          input int kill_off, input int rst_off, input bit b2b);
    int   t, n, dn, endc;
    ent_t e;
    @(posedge clk); #1;
    t = cyc;
    for (int i = 0; i < N; i++) begin
      op_vd[i]  = $realtobits(real'(i) + 1.0);
      op_vq[i]  = {$urandom, $urandom};
      op_sin[i] = {$urandom, $urandom};
      op_cos[i] = {$urandom, $urandom};
      vd_bus[i*W +: W]  = op_vd[i];
      vq_bus[i*W +: W]  = op_vq[i];
      sin_bus[i*W +: W] = op_sin[i];
      cos_bus[i*W +: W] = op_cos[i];
    end
    ch_en = mask;
    n = 0;
    for (int i = 0; i < N; i++) begin
      if (mask[i]) begin
        e = '{cyc: t + 1 + n, ch: CW'(i), a: op_vd[i], b: op_vq[i], c: op_sin[i], d: op_cos[i]};
        iss_q.push_back(e);
        if (kill_off < 0 || 25 + n != kill_off) begin
          e = '{cyc: t + 26 + n, ch: CW'(i), a: f_a(op_vd[i], op_vq[i]),
                b: f_b(op_vd[i], op_sin[i]), c: f_c(op_cos[i], op_vq[i]), d: '0};
          res_q.push_back(e);
        end
        n++;
      end
    end
    dn = (n == 0) ? t + 2 : t + n + 26;
    if (rst_off < 0) done_q.push_back(dn);
    if (force_off >= 0 || kill_off >= 0) exp_tag_err = 1;
    force_cyc = (force_off >= 0) ? t + force_off : -1;
    kill_cyc  = (kill_off >= 0) ? t + kill_off : -1;
    endc = (rst_off >= 0) ? t + 35 : (b2b ? dn : dn + 2);
    for (int c = t; c <= endc; c++) begin
      if (c > t) begin
        @(posedge clk); #1;
      end
      step_sta = (c == t) || (sta2_off >= 0 && c == t + sta2_off);
      if (sta2_off >= 0 && c == t + sta2_off) exp_overrun = 1;
      rst = (rst_off >= 0 && c == t + rst_off);
      if (rst) begin
        res_q.delete();
        done_q.delete();
        exp_overrun = 0;
        exp_tag_err = 0;
      end
      @(negedge clk);
      chk("busy", busy, (c >= t + 1 && c <= dn && !(rst_off >= 0 && c > t + rst_off)));
      if (rst_off >= 0 && c == t + rst_off + 1) chk_zero("mid_rst");
    end
    #1;
    step_sta  = 0;
    rst       = 0;
    force_cyc = -1;
    kill_cyc  = -1;
    chk("overrun", overrun, exp_overrun);
    chk("tag_err", tag_err, exp_tag_err);
    chk("iss_left", iss_q.size(), 0);
    chk("res_left", res_q.size(), 0);
    chk("done_left", done_q.size(), 0);
  endtask

  initial begin
    rst = 1; step_sta = 0; ch_en = '0;
    vd_bus = '0; vq_bus = '0; sin_bus = '0; cos_bus = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #1;
    rst = 0;
    repeat (2) @(posedge clk);

    run_step(4'b1111, -1, -1, -1, -1, 0);   // full step, ascending order
    run_step(4'b1010, 28, -1, -1, -1, 0);   // sparse mask; step_sta in the step_done cycle
    run_step(4'b0000, -1, -1, -1, -1, 0);   // empty step
    run_step(4'b1111, 10, -1, -1, -1, 1);   // overrun mid-step, next step right after
    run_step(4'b0110, -1, -1, -1, -1, 0);
    run_step(4'b1111, -1, 20, 27, -1, 0);   // stray done, then missing done for ch2
    run_step(4'b1111, -1, -1, -1, 15, 0);   // reset mid-step
    run_step(4'b1111, -1, -1, -1, -1, 0);
    for (int s = 0; s < 3; s++) run_step(N'($urandom_range(1, 15)), -1, -1, -1, -1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dq02abc_scheduler.md
Name: dq02abc_scheduler

Overview:
Time-multiplexes one pipelined dq0-to-abc transform unit (fixed latency, one start per cycle) across N_CH machine channels within each simulation time step. On a step start it snapshots the channel enable mask and issues enabled channels in ascending index order, one per cycle. It tags each issue with its channel index and returns the abc results with that index, then pulses step completion. Sits between the per-machine dq/theta registers and the shared transform unit.

Parameters:
N_CH, 4, number of channels (2..16)
LATENCY, 24, cycles from transform start to transform done (matches the transform unit)
W, 64, operand width (EXTENDED_SINGLE)
CW, 2, channel index width, equal to clog2(N_CH)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
step_sta  in  1  one-cycle pulse that starts a time step
ch_en  in  N_CH  channel enable mask, sampled only on an accepted step_sta
vd_bus  in  N_CH*W  packed Vd; channel i occupies bits [i*W +: W]
vq_bus  in  N_CH*W  packed Vq
sin_bus  in  N_CH*W  packed sin_theta
cos_bus  in  N_CH*W  packed cos_theta
dq_sta  out  1  start pulse to the transform unit
dq_Vd, dq_Vq, dq_sin, dq_cos  out  W each  operands to the transform unit
dq_Va, dq_Vb, dq_Vc  in  W each  transform results
dq_done  in  1  transform done strobe
res_Va, res_Vb, res_Vc  out  W each  registered results
res_ch  out  CW  channel index of the current result
res_valid  out  1  result strobe
step_done  out  1  one-cycle pulse when the step is complete
busy  out  1  high from an accepted step_sta until step_done
overrun  out  1  sticky: step_sta arrived while busy
tag_err  out  1  sticky: dq_done and tag-valid disagree

Behaviour:
- Reset (synchronous): every output goes to 0, including operand, result, sticky and tag registers. FSM goes to IDLE. Tag pipe is cleared.
- Reset mid-step: the step is abandoned. No step_done is produced. Any dq_done that follows is ignored; the transform unit is reset by the same rst.
- FSM states: IDLE, ISSUE, DRAIN, FIN.
- IDLE:
  - step_sta latches ch_en into a pending mask and sets busy.
  - Non-zero mask: go to ISSUE.
  - Zero mask: go to FIN.
- ISSUE, each cycle:
  - Select the lowest set bit of the pending mask.
  - Register that channel's four operands onto dq_*.
  - Pulse dq_sta.
  - Push {valid=1, index} into the tag pipe.
  - Clear the bit.
  - When the last bit is cleared, go to DRAIN.
  - One issue per cycle with no bubbles; disabled channels consume no cycles.
- dq_* operands hold their last value when dq_sta is low.
- Tag pipe: LATENCY stages of {valid, CW-bit index}, aligned to dq_done.
  - A tag pushed with dq_sta at cycle t emerges at t+LATENCY.
  - A cycle with no issue pushes valid=0.
- On dq_done with tag valid, at the next cycle:
  - res_V* <= dq_V*, res_ch <= tag index, res_valid = 1.
  - res_valid is 0 otherwise; res_* hold their values.
- DRAIN: count outstanding issues (issued minus returned). When the count reaches 0 after the final res_valid, go to FIN.
- FIN: step_done = 1 for one cycle, busy clears, then go to IDLE. busy is low in the cycle after step_done.
- Timing with all 4 channels enabled and step_sta at cycle T:
  - dq_sta at T+1..T+4
  - dq_done at T+25..T+28
  - res_valid at T+26..T+29
  - step_done at T+30
- Timing with zero mask: step_done at T+2.
- step_sta while busy: ignored, overrun set. overrun clears only on rst.
- tag_err is set in either case, clearing only on rst:
  - dq_done without a valid tag (the strobe is ignored, no res_valid), or
  - a valid tag without dq_done (the count is decremented anyway so DRAIN terminates).
- step_sta in the same cycle as step_done: ignored, overrun set. A new step may start the cycle after.
- Outstanding counter is clog2(N_CH+1) bits and never wraps, since at most N_CH are in flight.

Test Plan:
- rst, then ch_en=4'b1111, step_sta at T with distinct operands per channel (Vd_i = i+1.0) -> dq_sta T+1..T+4 carrying ch0..3 operands in order; res_ch 0,1,2,3 at T+26..T+29 with matching dq_V*; step_done at T+30; busy high T+1..T+30.
- ch_en=4'b1010 -> dq_sta at T+1 (ch1) and T+2 (ch3); res_ch 1 at T+26 and 3 at T+27; step_done at T+28.
- ch_en=4'b0000 -> no dq_sta, no res_valid; step_done at T+2.
- Second step_sta at T+10 during a full step -> ignored, overrun=1, only 4 results returned, step_done still at T+30. A new step_sta at T+31 is accepted.
- Model forces dq_done at T+20 (no tag valid) and suppresses the T+27 done -> tag_err=1, no res_valid at T+21, no result for ch2; step_done still at T+30.
- rst asserted at T+15 during a full step -> all outputs 0 at T+16; no res_valid and no step_done afterwards; a fresh step then completes normally.
